// File: rtl/morse_led_timer.sv
// Morse LED timer: accepts one dot/dash symbol per handshake and blinks the LED
// for 1 or 3 time units, then holds a 1- or 3-unit gap. A letter-final gap ends with a done pulse.
module morse_led_timer #(
  parameter int UNIT_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sym_valid,
  input  logic sym_long,
  input  logic sym_last,
  output logic sym_ready,
  output logic led,
  output logic busy,
  output logic done
);

  localparam int PW = $clog2(UNIT_CYCLES);
  localparam logic [PW-1:0] PRE_LAST = PW'(UNIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pre_cnt, pre_nxt;
  logic [1:0]    unit_cnt, unit_nxt;
  logic [1:0]    unit_final;
  logic          cap_long, cap_last;
  logic          done_nxt;
  logic          handshake;

  assign handshake = (state == IDLE) && sym_valid;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt  = state;
    pre_nxt    = pre_cnt;
    unit_nxt   = unit_cnt;
    done_nxt   = 1'b0;
    unit_final = 2'd0;
    unique case (state)
      IDLE: begin
        if (sym_valid) begin
          state_nxt = ON;
          pre_nxt   = '0;
          unit_nxt  = 2'd0;
        end
      end
      ON, GAP: begin
        // Long phase (dash / letter gap) spans three units, short phase one.
        unit_final = ((state == ON) ? cap_long : cap_last) ? 2'd2 : 2'd0;
        if (pre_cnt == PRE_LAST) begin
          pre_nxt = '0;
          if (unit_cnt == unit_final) begin
            unit_nxt  = 2'd0;
            state_nxt = (state == ON) ? GAP : IDLE;
            done_nxt  = (state == GAP) && cap_last;
          end else begin
            unit_nxt = unit_cnt + 2'd1;
          end
        end else begin
          pre_nxt = pre_cnt + PW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        pre_nxt   = '0;
        unit_nxt  = 2'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pre_cnt  <= '0;
      unit_cnt <= 2'd0;
      cap_long <= 1'b0;
      cap_last <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pre_cnt  <= pre_nxt;
      unit_cnt <= unit_nxt;
      done     <= done_nxt;
      if (handshake) begin
        cap_long <= sym_long;
        cap_last <= sym_last;
      end
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign sym_ready = (state == IDLE);
  assign busy      = ~sym_ready;
  assign led       = (state == ON);

endmodule

// File: tb/tb_morse_led_timer.sv
// Directed bench for morse_led_timer with UNIT_CYCLES=4: symbol timing, letter
// sequencing, input isolation while busy, reset abort and done-cycle handshake.
module tb_morse_led_timer;

  localparam int UNIT = 4;

  logic clk = 1'b0;
  logic rst_n, sym_valid, sym_long, sym_last;
  logic sym_ready, led, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;

  morse_led_timer #(.UNIT_CYCLES(UNIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sym_valid (sym_valid),
    .sym_long  (sym_long),
    .sym_last  (sym_last),
    .sym_ready (sym_ready),
    .led       (led),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && sym_valid && sym_ready) hs_count++;

  // Observed vector is {led, sym_ready, busy, done}.
  task automatic test_reset();
    logic [3:0] got;
    rst_n = 1'b0; sym_valid = 1'b1; sym_long = 1'b1; sym_last = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      got = {led, sym_ready, busy, done};
      n_checks++;
      if (got !== 4'b0100) begin
        n_fail++;
        $display("FAIL reset cyc %0d: got %b expected 0100", i, got);
      end
    end
    sym_valid = 1'b0; sym_long = 1'b0; sym_last = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    got = {led, sym_ready, busy, done};
    n_checks++;
    if (got !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected 0100", got);
    end
  endtask

  // All four dot/dash x last/non-last combinations with hand-derived durations.
  task automatic test_symbols();
    logic [1:0] kinds [4];
    logic [3:0] got, exp;
    int on_len, gap_len, end_i;
    kinds[0] = 2'b00; kinds[1] = 2'b11; kinds[2] = 2'b10; kinds[3] = 2'b01;
    for (int k = 0; k < 4; k++) begin
      on_len  = kinds[k][1] ? 3 * UNIT : UNIT;
      gap_len = kinds[k][0] ? 3 * UNIT : UNIT;
      end_i   = on_len + gap_len + 1;
      @(negedge clk);
      sym_valid = 1'b1; sym_long = kinds[k][1]; sym_last = kinds[k][0];
      @(posedge clk); #1;
      sym_valid = 1'b0;
      for (int i = 1; i <= end_i + 1; i++) begin
        @(negedge clk);
        got = {led, sym_ready, busy, done};
        exp = {i <= on_len, i >= end_i, i < end_i, kinds[k][0] && (i == end_i)};
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL symbol long=%b last=%b cyc %0d: got %b expected %b",
                   kinds[k][1], kinds[k][0], i, got, exp);
        end
      end
    end
    sym_long = 1'b0; sym_last = 1'b0;
  endtask

  task automatic test_letter_a();
    logic [3:0] got, exp;
    int hs_base;
    @(negedge clk);
    hs_base = hs_count;
    sym_valid = 1'b1; sym_long = 1'b0; sym_last = 1'b0;
    @(posedge clk); #1;
    sym_long = 1'b1; sym_last = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      got = {led, sym_ready, busy, done};
      exp = {(i <= 4) || (i >= 10 && i <= 21), (i == 9) || (i >= 34),
             !((i == 9) || (i >= 34)), i == 34};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL letter_a cyc %0d: got %b expected %b", i, got, exp);
      end
      if (i == 33) sym_valid = 1'b0;
    end
    n_checks++;
    if (hs_count - hs_base !== 2) begin
      n_fail++;
      $display("FAIL letter_a_handshakes: got %0d expected 2", hs_count - hs_base);
    end
    sym_long = 1'b0; sym_last = 1'b0;
  endtask

  task automatic test_toggle_during_on();
    logic [3:0] got, exp;
    @(negedge clk);
    sym_valid = 1'b1; sym_long = 1'b0; sym_last = 1'b0;
    @(posedge clk); #1;
    sym_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      got = {led, sym_ready, busy, done};
      exp = {i <= 4, i >= 9, i < 9, 1'b0};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL toggle cyc %0d: got %b expected %b", i, got, exp);
      end
      if (i <= 8) begin
        sym_long = ~sym_long;
        sym_last = (i % 3 == 0) ? 1'b1 : ~sym_last;
      end
    end
    sym_long = 1'b0; sym_last = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [3:0] got, exp;
    @(negedge clk);
    sym_valid = 1'b1; sym_long = 1'b1; sym_last = 1'b1;
    @(posedge clk); #1;
    sym_valid = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      got = {led, sym_ready, busy, done};
      exp = (i <= 6) ? 4'b1010 : 4'b0100;
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_abort cyc %0d: got %b expected %b", i, got, exp);
      end
      if (i == 6) rst_n = 1'b0;
      if (i == 7) rst_n = 1'b1;
    end
    sym_long = 1'b0; sym_last = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] got, exp;
    int hs_base;
    @(negedge clk);
    hs_base = hs_count;
    sym_valid = 1'b1; sym_long = 1'b1; sym_last = 1'b1;
    @(posedge clk); #1;
    sym_long = 1'b0; sym_last = 1'b0;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      got = {led, sym_ready, busy, done};
      exp = {(i <= 12) || (i >= 26 && i <= 29), (i == 25) || (i >= 34),
             !((i == 25) || (i >= 34)), i == 25};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %b expected %b", i, got, exp);
      end
      if (i == 26) sym_valid = 1'b0;
    end
    n_checks++;
    if (hs_count - hs_base !== 2) begin
      n_fail++;
      $display("FAIL back_to_back_handshakes: got %0d expected 2", hs_count - hs_base);
    end
  endtask

  initial begin
    test_reset();
    test_symbols();
    test_letter_a();
    test_toggle_during_on();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
